// File: rtl/pps_table_parser.sv
// PPS RBSP parser with a MAX_PPS-entry parameter-set table.
// Fields stage in shadow registers and commit atomically on success.
module pps_table_parser #(
  parameter int MAX_PPS = 4,
  parameter int ID_W    = 2,
  parameter int UE_W    = 8,
  parameter int REF_W   = 5,
  localparam int ENT_W  = 36 + 2*REF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rbsp_ready_in,
  input  logic [2:0]        rbsp_in,
  input  logic [UE_W-1:0]   ue_in,
  input  logic [UE_W-1:0]   se_in,
  input  logic [4:0]        eg_len_in,
  input  logic              more_rbsp_data_in,
  output logic [4:0]        forward_len_out,
  output logic              forward_valid_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out,
  output logic [3:0]        err_code_out,
  input  logic [ID_W-1:0]   rd_id_in,
  output logic              rd_valid_out,
  output logic [ENT_W-1:0]  rd_data_out
);

  typedef enum logic [4:0] {
    S_IDLE, S_PPS_ID, S_SPS_ID, S_F2, S_NSG,
    S_REF0, S_REF1, S_F3W, S_QP, S_QS, S_CQP,
    S_F3D, S_EXT, S_T8, S_CQP2, S_COMMIT, S_ERR
  } state_t;

  localparam logic [UE_W-1:0] PPS_LIM = UE_W'(MAX_PPS);
  localparam logic [UE_W-1:0] SPS_MAX = UE_W'(31);
  localparam logic [UE_W-1:0] REF_MAX = UE_W'((1 << REF_W) - 1);
  localparam logic signed [UE_W-1:0] QP_MIN = UE_W'(-26);
  localparam logic signed [UE_W-1:0] QP_MAX = UE_W'(25);
  localparam logic signed [UE_W-1:0] CQ_MIN = UE_W'(-12);
  localparam logic signed [UE_W-1:0] CQ_MAX = UE_W'(12);

  state_t r_state, w_next;

  logic              w_cons, w_adv;
  logic [4:0]        w_len;
  logic [3:0]        w_code;
  logic signed [UE_W-1:0] w_se;
  logic              w_qp_bad, w_cq_bad;

  logic [ID_W-1:0]   r_pps;
  logic [4:0]        r_sps;
  logic              r_ent, r_po, r_wp;
  logic [REF_W-1:0]  r_ref0, r_ref1;
  logic [1:0]        r_bip;
  logic [5:0]        r_qp, r_qs;
  logic [4:0]        r_cqp, r_cqp2;
  logic              r_dbf, r_cip, r_rpc, r_t8;
  logic [ENT_W-1:0]  w_ent;

  logic [ENT_W-1:0]  r_tab [MAX_PPS];
  logic [MAX_PPS-1:0] r_vld;
  logic              r_done, r_err, r_rd_vld;
  logic [3:0]        r_code;
  logic [ENT_W-1:0]  r_rd_data;

  assign w_se     = se_in;
  assign w_qp_bad = (w_se < QP_MIN) || (w_se > QP_MAX);
  assign w_cq_bad = (w_se < CQ_MIN) || (w_se > CQ_MAX);

  assign w_ent = {r_sps, r_ent, r_po, r_ref0, r_ref1, r_wp, r_bip,
                  r_qp, r_qs, r_cqp, r_dbf, r_cip, r_rpc, r_t8, r_cqp2};

  always_comb begin
    w_next = r_state;
    w_cons = 1'b0;
    w_len  = '0;
    w_code = '0;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_PPS_ID;
      S_PPS_ID: begin
        w_cons = 1'b1; w_len = eg_len_in; w_next = S_SPS_ID;
        if (ue_in >= PPS_LIM) w_code = 4'd1;
      end
      S_SPS_ID: begin
        w_cons = 1'b1; w_len = eg_len_in; w_next = S_F2;
        if (ue_in > SPS_MAX) w_code = 4'd2;
      end
      S_F2: begin
        w_cons = 1'b1; w_len = 5'd2; w_next = S_NSG;
      end
      S_NSG: begin
        w_cons = 1'b1; w_len = eg_len_in; w_next = S_REF0;
        if (ue_in != '0) w_code = 4'd3;
      end
      S_REF0: begin
        w_cons = 1'b1; w_len = eg_len_in; w_next = S_REF1;
        if (ue_in > REF_MAX) w_code = 4'd4;
      end
      S_REF1: begin
        w_cons = 1'b1; w_len = eg_len_in; w_next = S_F3W;
        if (ue_in > REF_MAX) w_code = 4'd4;
      end
      S_F3W: begin
        w_cons = 1'b1; w_len = 5'd3; w_next = S_QP;
        if (rbsp_in[1:0] == 2'd3) w_code = 4'd5;
      end
      S_QP: begin
        w_cons = 1'b1; w_len = eg_len_in; w_next = S_QS;
        if (w_qp_bad) w_code = 4'd6;
      end
      S_QS: begin
        w_cons = 1'b1; w_len = eg_len_in; w_next = S_CQP;
        if (w_qp_bad) w_code = 4'd6;
      end
      S_CQP: begin
        w_cons = 1'b1; w_len = eg_len_in; w_next = S_F3D;
        if (w_cq_bad) w_code = 4'd7;
      end
      S_F3D: begin
        w_cons = 1'b1; w_len = 5'd3; w_next = S_EXT;
      end
      S_EXT:    w_next = more_rbsp_data_in ? S_T8 : S_COMMIT;
      S_T8: begin
        w_cons = 1'b1; w_len = 5'd2; w_next = S_CQP2;
        if (rbsp_in[1]) w_code = 4'd8;
      end
      S_CQP2: begin
        w_cons = 1'b1; w_len = eg_len_in; w_next = S_COMMIT;
        if (w_cq_bad) w_code = 4'd7;
      end
      S_COMMIT: w_next = S_IDLE;
      S_ERR:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    w_adv = w_cons & rbsp_ready_in;
    if (w_cons && !w_adv)
      w_next = r_state;
    else if (w_adv && (w_code != '0))
      w_next = S_ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pps  <= '0; r_sps  <= '0; r_ent <= 1'b0; r_po  <= 1'b0;
      r_ref0 <= '0; r_ref1 <= '0; r_wp  <= 1'b0; r_bip <= '0;
      r_qp   <= '0; r_qs   <= '0; r_cqp <= '0;   r_dbf <= 1'b0;
      r_cip  <= 1'b0; r_rpc <= 1'b0; r_t8 <= 1'b0; r_cqp2 <= '0;
      for (int i = 0; i < MAX_PPS; i++) r_tab[i] <= '0;
      r_vld     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_code    <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_done    <= (r_state == S_COMMIT);
      r_err     <= (r_state == S_ERR);
      // read-before-write: a commit this edge is seen on the next read
      r_rd_vld  <= r_vld[rd_id_in];
      r_rd_data <= r_tab[rd_id_in];
      if (r_state == S_IDLE && start) r_code <= '0;
      if (w_adv && (w_code != '0)) r_code <= w_code;
      if (w_adv && (w_code == '0)) begin
        unique case (r_state)
          S_PPS_ID: r_pps  <= ue_in[ID_W-1:0];
          S_SPS_ID: r_sps  <= ue_in[4:0];
          S_F2:     begin r_ent <= rbsp_in[2]; r_po <= rbsp_in[1]; end
          S_REF0:   r_ref0 <= ue_in[REF_W-1:0];
          S_REF1:   r_ref1 <= ue_in[REF_W-1:0];
          S_F3W:    begin r_wp <= rbsp_in[2]; r_bip <= rbsp_in[1:0]; end
          S_QP:     r_qp   <= se_in[5:0];
          S_QS:     r_qs   <= se_in[5:0];
          S_CQP:    r_cqp  <= se_in[4:0];
          S_F3D: begin
            r_dbf <= rbsp_in[2]; r_cip <= rbsp_in[1]; r_rpc <= rbsp_in[0];
          end
          S_T8:     r_t8   <= rbsp_in[2];
          S_CQP2:   r_cqp2 <= se_in[4:0];
          default: ;
        endcase
      end
      if (r_state == S_EXT && !more_rbsp_data_in) begin
        r_t8   <= 1'b0;
        r_cqp2 <= r_cqp;
      end
      if (r_state == S_COMMIT) begin
        r_tab[r_pps] <= w_ent;
        r_vld[r_pps] <= 1'b1;
      end
    end
  end

  assign forward_valid_out = w_adv;
  assign forward_len_out   = w_len;
  assign busy_out          = (r_state != S_IDLE);
  assign done_out          = r_done;
  assign err_out           = r_err;
  assign err_code_out      = r_code;
  assign rd_valid_out      = r_rd_vld;
  assign rd_data_out       = r_rd_data;

endmodule
